// File: rtl/io_timer_pkg.sv
// Shared time-base constants and types for the IO timer blocks.
// The microsecond counter imports the same constant, so both time bases stay identical.
package io_timer_pkg;

  localparam int unsigned SYS_CLK_HZ       = 50_000_000;
  localparam int unsigned CLKS_PER_US_DFLT = SYS_CLK_HZ / 1_000_000;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } timer_state_e;

endpackage

// File: rtl/us_prescaler.sv
// Mod-CLKS_PER_US counter with enable and synchronous clear.
// o_tick is a one-cycle pulse during the terminal-count cycle.
module us_prescaler
  import io_timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = CLKS_PER_US_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == TC);
  assign o_tick = w_tick;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/us_timer.sv
// Programmable microsecond countdown timer, one-shot or auto-reload, with one-cycle irq on expiry.
//   state       | meaning
//   ST_IDLE     | no countdown in progress, remaining = 0
//   ST_COUNTING | counting down, remaining >= 1, prescaler running
module us_timer
  import io_timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = CLKS_PER_US_DFLT,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             value_we,
  input  logic [WIDTH-1:0] value_in,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic             irq
);

  timer_state_e     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_remaining, w_remaining_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_periodic, w_periodic_nxt;
  logic             r_irq, w_irq_nxt;
  logic [WIDTH-1:0] w_start_val;
  logic             w_busy;
  logic             w_tick;

  assign w_busy = (r_state == ST_COUNTING);

  us_prescaler #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_busy),
    .i_clr  (stop | start),
    .o_tick (w_tick)
  );

  // A write in the same cycle as start is what start loads.
  assign w_start_val = value_we ? value_in : r_reload;

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_reload_nxt    = value_we ? value_in : r_reload;
    w_periodic_nxt  = r_periodic;
    w_irq_nxt       = 1'b0;

    if (stop) begin
      w_state_nxt     = ST_IDLE;
      w_remaining_nxt = '0;
    end else if (start) begin
      w_periodic_nxt = periodic;
      if (w_start_val != '0) begin
        w_state_nxt     = ST_COUNTING;
        w_remaining_nxt = w_start_val;
      end else begin
        w_state_nxt     = ST_IDLE;
        w_remaining_nxt = '0;
        w_irq_nxt       = 1'b1;
      end
    end else if (w_busy && w_tick) begin
      if (r_remaining > WIDTH'(1)) begin
        w_remaining_nxt = r_remaining - 1'b1;
      end else begin
        w_irq_nxt = 1'b1;
        // A zero reload cannot sustain a period, so it degrades to one-shot expiry.
        if (r_periodic && (r_reload != '0)) begin
          w_remaining_nxt = r_reload;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_remaining_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_reload    <= '0;
      r_periodic  <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_reload    <= w_reload_nxt;
      r_periodic  <= w_periodic_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  assign busy      = w_busy;
  assign remaining = r_remaining;
  assign irq       = r_irq;

endmodule

// File: tb/tb_us_timer.sv
// Self-checking bench for us_timer: vector table plus hand-written corner sequences.
// Expected irq edge indices are queued at start and matched as irq pulses appear.
module tb_us_timer;

  localparam int CPU = 50;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         value_we = 1'b0;
  logic [W-1:0] value_in = '0;
  logic         periodic = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         busy;
  logic [W-1:0] remaining;
  logic         irq;

  always #5 clk = ~clk;

  us_timer #(
    .CLKS_PER_US (CPU),
    .WIDTH       (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value_we  (value_we),
    .value_in  (value_in),
    .periodic  (periodic),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .remaining (remaining),
    .irq       (irq)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // irq scoreboard: every pulse must match the oldest expected edge index
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      int t;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL irq_unexpected: got irq=1 expected none (edge %0d)", edge_cnt);
      end else begin
        t = exp_q.pop_front();
        chk("irq_edge", 64'(edge_cnt), 64'(t));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_to(input int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  // Issues start at the next edge; queues k expected expiries (n==0 queues the immediate one).
  task automatic do_start(input logic [W-1:0] n, input logic per, input logic wr,
                          input int k, output int e0);
    @(negedge clk);
    value_in = n;
    value_we = wr;
    periodic = per;
    start    = 1'b1;
    e0 = edge_cnt + 1;
    if (k > 0) begin
      if (n == '0) exp_q.push_back(e0);
      else for (int j = 1; j <= k; j++) exp_q.push_back(e0 + j * int'(n) * CPU);
    end
    @(negedge clk);
    value_we = 1'b0;
    start    = 1'b0;
    periodic = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic write_val(input logic [W-1:0] v);
    value_in = v;
    value_we = 1'b1;
    @(negedge clk);
    value_we = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic         per;
    int           k;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int e0, e1;
    vecs[0] = '{n: 32'd3, per: 1'b0, k: 1};
    vecs[1] = '{n: 32'd1, per: 1'b0, k: 1};
    vecs[2] = '{n: 32'd0, per: 1'b0, k: 1};
    vecs[3] = '{n: 32'd0, per: 1'b1, k: 1};
    vecs[4] = '{n: 32'd2, per: 1'b1, k: 3};
    vecs[5] = '{n: 32'd5, per: 1'b1, k: 2};
    vecs[6] = '{n: 32'd7, per: 1'b0, k: 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_remaining", 64'(remaining), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      do_start(vecs[v].n, vecs[v].per, 1'b1, vecs[v].k, e0);
      if (vecs[v].n == '0) begin
        wait_to(e0 + 200);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_remaining", 64'(remaining), 64'd0);
      end else if (!vecs[v].per) begin
        for (int j = 0; j < int'(vecs[v].n); j++) begin
          wait_to(e0 + j * CPU + 25);
          chk("os_remaining", 64'(remaining), 64'(vecs[v].n) - 64'(j));
          chk("os_busy", 64'(busy), 64'd1);
        end
        wait_to(e0 + int'(vecs[v].n) * CPU);
        chk("os_busy_fall", 64'(busy), 64'd0);
        wait_to(e0 + int'(vecs[v].n) * CPU + 3);
        chk("os_end_remaining", 64'(remaining), 64'd0);
      end else begin
        wait_to(e0 + vecs[v].k * int'(vecs[v].n) * CPU + 10);
        chk("per_busy", 64'(busy), 64'd1);
        chk("per_reloaded", 64'(remaining), 64'(vecs[v].n));
        pulse_stop();
        chk("per_stop_busy", 64'(busy), 64'd0);
        chk("per_stop_remaining", 64'(remaining), 64'd0);
      end
      chk("vec_queue_drained", 64'(exp_q.size()), 64'd0);
      repeat (5) @(negedge clk);
    end

    // periodic N=2, reload rewritten to 4 mid-run
    do_start(32'd2, 1'b1, 1'b1, 2, e0);
    wait_to(e0 + 150);
    write_val(32'd4);
    exp_q.push_back(e0 + 400);
    exp_q.push_back(e0 + 600);
    wait_to(e0 + 300);
    chk("rew_busy", 64'(busy), 64'd1);
    chk("rew_remaining", 64'(remaining), 64'd2);
    wait_to(e0 + 610);
    pulse_stop();
    chk("rew_stopped", 64'(busy), 64'd0);

    // periodic with reload cleared before the next expiry ends as one-shot
    do_start(32'd1, 1'b1, 1'b1, 1, e0);
    wait_to(e0 + 60);
    write_val(32'd0);
    exp_q.push_back(e0 + 100);
    wait_to(e0 + 110);
    chk("rel0_busy", 64'(busy), 64'd0);
    chk("rel0_remaining", 64'(remaining), 64'd0);

    // restart while remaining==1: the aborted run must not fire
    do_start(32'd3, 1'b0, 1'b1, 0, e0);
    wait_to(e0 + 120);
    chk("restart_rem1", 64'(remaining), 64'd1);
    do_start(32'd3, 1'b0, 1'b0, 1, e1);
    chk("restart_remaining", 64'(remaining), 64'd3);
    wait_to(e1 + 153);
    chk("restart_done", 64'(busy), 64'd0);

    // stop on the expiry edge suppresses irq
    do_start(32'd2, 1'b0, 1'b1, 0, e0);
    wait_to(e0 + 99);
    chk("race_rem1", 64'(remaining), 64'd1);
    pulse_stop();
    chk("race_busy", 64'(busy), 64'd0);
    chk("race_irq", 64'(irq), 64'd0);
    repeat (150) @(negedge clk);

    // start and stop together: stop wins
    do_start(32'd5, 1'b0, 1'b1, 0, e0);
    repeat (30) @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_remaining", 64'(remaining), 64'd0);
    repeat (300) @(negedge clk);

    // large reload: first tick only decrements
    do_start(32'hFFFF_FFFF, 1'b0, 1'b1, 0, e0);
    wait_to(e0 + 49);
    chk("big_first", 64'(remaining), 64'hFFFF_FFFF);
    wait_to(e0 + 50);
    chk("big_tick", 64'(remaining), 64'hFFFF_FFFE);
    chk("big_busy", 64'(busy), 64'd1);
    pulse_stop();

    // reset mid-count cancels the run and clears the reload register
    do_start(32'd3, 1'b0, 1'b1, 1, e0);
    wait_to(e0 + 60);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_remaining", 64'(remaining), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (200) @(negedge clk);
    do_start(32'd0, 1'b0, 1'b0, 1, e0);
    wait_to(e0 + 5);
    chk("post_rst_busy", 64'(busy), 64'd0);

    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
